// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared constants and encodings for the multi-channel pulse generator.
//   mode_e     : channel operating mode (periodic / one-shot)
//   state_e    : per-channel FSM state encoding
//   MIN_PERIOD : smallest legal period; shorter requests are raised to this
// The per-channel config record {period, width, mode} is sized by CNT_W and is
// therefore declared as ch_cfg_t inside pulse_gen_channel, built on mode_e.
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_generator_mc_if.sv
// -----------------------------------------------------------------------------
// pulse_generator_mc_if
// Configuration port of pulse_generator_mc (valid/ready transfer).
//   cfg_valid  : request from the master
//   cfg_ready  : accept from the generator; transfer on valid && ready
//   cfg_ch     : target channel
//   cfg_period : period P in cycles
//   cfg_width  : high width W in cycles
//   cfg_mode   : 0 = periodic, 1 = one-shot
// -----------------------------------------------------------------------------
interface pulse_generator_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_width;
    logic             cfg_mode;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_width, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_width, cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/pulse_gen_channel.sv
// -----------------------------------------------------------------------------
// pulse_gen_channel
// One pulse channel: FSM, period counter, active config, shadow config and
// pending flag.
//   clk, rst        : clock, synchronous active-high reset
//   en, trig        : channel enable (level), one-shot start (level)
//   sync_in         : frame marker (only with PULSE_GEN_MC_SYNC_EN defined)
//   wr, wr_*        : already-clamped config write into the shadow register
//   pulse_out, busy : registered pulse, channel ACTIVE
//   pending         : shadow config waiting to be applied
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | counter parked at 0, output low, waiting for en (and trig)
//   ST_ACTIVE | counting 0..P-1, output high while cnt < W
// -----------------------------------------------------------------------------
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trig,
`ifdef PULSE_GEN_MC_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_width,
    input  mode_e            wr_mode,
    output logic             pulse_out,
    output logic             busy,
    output logic             pending
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] width;
        mode_e            mode;
    } ch_cfg_t;

    localparam ch_cfg_t CFG_RST = '{
        period: CNT_W'(DEFAULT_PERIOD),
        width:  CNT_W'(1),
        mode:   MODE_PERIODIC
    };

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             pending_q, pending_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    ch_cfg_t          nxt_cfg;
    logic             restart;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = pulse_q;
        pending_d = pending_q;
        act_d     = act_q;
        shd_d     = shd_q;

        // Config that governs the next period to start.
        nxt_cfg = pending_q ? shd_q : act_q;

        restart = (state_q == ST_ACTIVE) && (cnt_q == act_q.period - CNT_W'(1));
`ifdef PULSE_GEN_MC_SYNC_EN
        // Frame marker forces a boundary on running periodic channels.
        if (sync_in && (state_q == ST_ACTIVE) && (act_q.mode == MODE_PERIODIC)) begin
            restart = 1'b1;
        end
`endif

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
            if ((state_q == ST_IDLE) && pending_q) begin
                act_d     = shd_q;
                pending_d = 1'b0;
            end
        end else if (state_q == ST_IDLE) begin
            act_d     = nxt_cfg;
            pending_d = 1'b0;
            if ((nxt_cfg.mode == MODE_PERIODIC) || trig) begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
                pulse_d = (nxt_cfg.width != '0);
            end
        end else if (restart) begin
            act_d     = nxt_cfg;
            pending_d = 1'b0;
            cnt_d     = '0;
            // A finished one-shot, or a switch to one-shot, parks in IDLE.
            if ((act_q.mode == MODE_ONESHOT) || (nxt_cfg.mode == MODE_ONESHOT)) begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
            end else begin
                pulse_d = (nxt_cfg.width != '0);
            end
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            pulse_d = (cnt_q + CNT_W'(1)) < act_q.width;
        end

        // Writes only arrive while pending is clear, so they never race an
        // apply; a write on a boundary cycle waits for the following one.
        if (wr) begin
            shd_d     = '{period: wr_period, width: wr_width, mode: wr_mode};
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            act_q     <= CFG_RST;
            shd_q     <= CFG_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = (state_q == ST_ACTIVE);
    assign pending   = pending_q;

endmodule

// File: rtl/pulse_generator_mc.sv
// -----------------------------------------------------------------------------
// pulse_generator_mc
// Multi-channel programmable pulse / strobe generator.
//   clk, rst  : clock, synchronous active-high reset
//   cfg       : pulse_generator_mc_if.slave config port (valid/ready)
//   ch_en     : per-channel enable (level)
//   trig      : per-channel one-shot start (level, sampled)
//   sync_in   : frame marker, present only when PULSE_GEN_MC_SYNC_EN is defined
//   pulse_out : registered pulse outputs
//   busy      : channel ACTIVE
// Optional feature macro: PULSE_GEN_MC_SYNC_EN (phase-align periodic channels).
// -----------------------------------------------------------------------------
module pulse_generator_mc
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    pulse_generator_mc_if.slave cfg,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [NUM_CH-1:0]   trig,
`ifdef PULSE_GEN_MC_SYNC_EN
    input  logic                sync_in,
`endif
    output logic [NUM_CH-1:0]   pulse_out,
    output logic [NUM_CH-1:0]   busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    pending;
    logic [2**CH_W-1:0]   pending_ext;
    logic                 xfer;
    logic [CNT_W-1:0]     clp_period;
    logic [CNT_W-1:0]     clp_width;

    // Unused channel codes read as "not pending": accepted and dropped.
    always_comb begin
        pending_ext               = '0;
        pending_ext[NUM_CH-1:0]   = pending;
    end

    assign cfg.cfg_ready = ~pending_ext[cfg.cfg_ch];
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        clp_period = (cfg.cfg_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : cfg.cfg_period;
        clp_width  = (cfg.cfg_width >= clp_period) ? (clp_period - CNT_W'(1)) : cfg.cfg_width;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (ch_en[i]),
            .trig      (trig[i]),
`ifdef PULSE_GEN_MC_SYNC_EN
            .sync_in   (sync_in),
`endif
            .wr        (xfer && (cfg.cfg_ch == CH_W'(i))),
            .wr_period (clp_period),
            .wr_width  (clp_width),
            .wr_mode   (mode_e'(cfg.cfg_mode)),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .pending   (pending[i])
        );
    end

endmodule

// File: tb/tb_pulse_generator_mc.sv
module tb_pulse_generator_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DEF_P  = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] pulse_out;
    logic [NUM_CH-1:0] busy;
`ifdef PULSE_GEN_MC_SYNC_EN
    logic              sync_in;
`endif

    int n_vec = 0;
    int n_err = 0;

    pulse_generator_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

    pulse_generator_mc #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cfg_if),
        .ch_en     (ch_en),
        .trig      (trig),
`ifdef PULSE_GEN_MC_SYNC_EN
        .sync_in   (sync_in),
`endif
        .pulse_out (pulse_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int ch, input int p, input int w, input logic m);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_period = 32'(p);
        cfg_if.cfg_width  = 32'(w);
        cfg_if.cfg_mode   = m;
        step();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        ch_en             = '0;
        trig              = '0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_width  = '0;
        cfg_if.cfg_mode   = 1'b0;
`ifdef PULSE_GEN_MC_SYNC_EN
        sync_in           = 1'b0;
`endif
        step();
        step();
        chk("rst_pulse", 32'(pulse_out), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);

        // Reset defaults: 1-cycle tick every DEF_P cycles.
        rst   = 1'b0;
        ch_en = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("legacy_pulse", 32'(pulse_out[0]), 32'(((k - 1) % DEF_P) == 0));
            if (k == 1) chk("legacy_busy", 32'(busy[0]), 32'd1);
        end
        ch_en = 4'b0000;
        step();
        chk("legacy_off_busy", 32'(busy[0]), 32'd0);

        // Test 1: ch0 P=5 W=1.
        cfg_write(0, 5, 1, 1'b0);
        chk("idle_pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        step();
        chk("idle_apply_ready", 32'(cfg_if.cfg_ready), 32'd1);
        ch_en[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("p5_pulse", 32'(pulse_out[0]), 32'(((k - 1) % 5) == 0));
        end
        ch_en[0] = 1'b0;
        step();

        // Test 5: drop enable mid-pulse, then restart.
        cfg_write(0, 10, 5, 1'b0);
        step();
        ch_en[0] = 1'b1;
        step();
        step();
        step();
        chk("trunc_pre_pulse", 32'(pulse_out[0]), 32'd1);
        ch_en[0] = 1'b0;
        step();
        chk("trunc_pulse", 32'(pulse_out[0]), 32'd0);
        chk("trunc_busy",  32'(busy[0]),      32'd0);
        ch_en[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("reen_pulse", 32'(pulse_out[0]), 32'(k <= 5));
            if (k == 1) chk("reen_busy", 32'(busy[0]), 32'd1);
        end

        // Test 2: reconfigure ch1 mid-period, applied at the boundary.
        cfg_write(1, 8, 3, 1'b0);
        step();
        ch_en[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 3) begin
                cfg_if.cfg_valid  = 1'b1;
                cfg_if.cfg_ch     = 2'd1;
                cfg_if.cfg_period = 32'd4;
                cfg_if.cfg_width  = 32'd2;
                cfg_if.cfg_mode   = 1'b0;
            end
            if (k == 4) cfg_if.cfg_valid = 1'b0;
            #1;
            chk("reconf_pulse", 32'(pulse_out[1]),
                32'((k <= 8) ? ((k - 1) < 3) : (((k - 9) % 4) < 2)));
            chk("reconf_ready", 32'(cfg_if.cfg_ready), 32'(!((k >= 4) && (k <= 8))));
        end

        // Test 3: ch2 one-shot P=6 W=2.
        cfg_write(2, 6, 2, 1'b1);
        step();
        ch_en[2] = 1'b1;
        step();
        chk("os_wait_busy", 32'(busy[2]), 32'd0);
        trig[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) trig[2] = 1'b0;
            if (k == 3) trig[2] = 1'b1;
            if (k == 4) trig[2] = 1'b0;
            chk("os_busy",  32'(busy[2]),      32'(k <= 6));
            chk("os_pulse", 32'(pulse_out[2]), 32'(k <= 2));
        end

        // Test 4: clamping on ch3.
        cfg_write(3, 0, 9, 1'b0);
        step();
        ch_en[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("clamp_pulse", 32'(pulse_out[3]), 32'(k % 2));
            chk("clamp_busy",  32'(busy[3]),      32'd1);
        end
        ch_en[3] = 1'b0;
        step();
        cfg_write(3, 5, 0, 1'b0);
        step();
        ch_en[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("silent_busy",  32'(busy[3]),      32'd1);
            chk("silent_pulse", 32'(pulse_out[3]), 32'd0);
        end

        // Test 6: reset with all channels active and a pending config.
        trig[2] = 1'b1;
        cfg_write(0, 3, 1, 1'b0);
        chk("mid_pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("mid_all_busy",   32'(busy),             32'hF);
        rst = 1'b1;
        step();
        chk("mid_rst_pulse", 32'(pulse_out), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        rst     = 1'b0;
        ch_en   = '0;
        trig    = '0;
        step();

`ifdef PULSE_GEN_MC_SYNC_EN
        cfg_write(0, 5, 1, 1'b0);
        step();
        cfg_write(1, 7, 1, 1'b0);
        step();
        ch_en = 4'b0001;
        step();
        step();
        ch_en = 4'b0011;
        step();
        step();
        step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk("sync_align", 32'(pulse_out[1:0]), 32'd3);
        step();
        chk("sync_after", 32'(pulse_out[1:0]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
